// File: rtl/pad_input_conditioner.sv
// Conditions asynchronous pad inputs for the core clock domain: synchronizer, debounce, edge pulses, sticky flags.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clk edges from first sampling edge to value_o/rise_o/fall_o; pending_o/irq_o one later.
// Backpressure: none; outputs are level/pulse registers, pending bits hold until cleared by clear_i.
module pad_input_conditioner #(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pad_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] clear_i,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] pending_o,
  output logic             irq_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]    r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_pending;
  logic             r_irq;

  logic [WIDTH-1:0] w_synced;
  logic [WIDTH-1:0] w_pending_nxt;

  assign w_synced      = r_sync[SYNC_STAGES-1];
  // Registered pulses feed the sticky flags, so a pulse beats a same-cycle clear.
  assign w_pending_nxt = (r_pending & ~clear_i) | r_rise | r_fall;

  // Synchronizer chain: free-running regardless of enable so the level is fresh on re-enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= RESET_VALUE;
    end else begin
      r_sync[0] <= pad_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // Per-bit debounce: accept a new level only after it persists DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_value <= RESET_VALUE;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else if (!enable_i) begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        if (w_synced[i] == r_value[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_value[i] <= w_synced[i];
          r_rise[i]  <= w_synced[i];
          r_fall[i]  <= ~w_synced[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Sticky edge flags and their OR-reduced interrupt, updated together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_irq     <= |w_pending_nxt;
    end
  end

  assign value_o   = r_value;
  assign rise_o    = r_rise;
  assign fall_o    = r_fall;
  assign pending_o = r_pending;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Scoreboard bench for pad_input_conditioner: window-based reference model, directed scenarios then random traffic.
module tb_pad_input_conditioner;
  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] pad_i;
  logic         enable_i;
  logic [W-1:0] clear_i;
  logic [W-1:0] value_o, rise_o, fall_o, pending_o;
  logic         irq_o;

  pad_input_conditioner #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .RESET_VALUE('0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pad_i(pad_i), .enable_i(enable_i), .clear_i(clear_i),
    .value_o(value_o), .rise_o(rise_o), .fall_o(fall_o), .pending_o(pending_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] value;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] pend;
    logic         irq;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] s;
    logic         en;
  } hent_t;

  logic [W-1:0] m_pipe [$];   // pad samples in flight, oldest first
  hent_t        hist   [$];   // last DB cycles of (synced level, enable)
  exp_t         m;
  exp_t         expq   [$];

  task automatic model_reset();
    m_pipe.delete();
    for (int s = 0; s < SYNC; s++) m_pipe.push_back('0);
    hist.delete();
    m = '0;
  endtask

  task automatic model_edge(input logic rst_n, input logic [W-1:0] pad,
                            input logic en, input logic [W-1:0] clr);
    hent_t        e;
    logic [W-1:0] new_pend;
    logic [W-1:0] acc;
    if (!rst_n) begin
      model_reset();
    end else begin
      e.s  = m_pipe[0];
      e.en = en;
      hist.push_back(e);
      if (hist.size() > DB) void'(hist.pop_front());
      new_pend = (m.pend & ~clr) | m.rise | m.fall;
      acc = '0;
      // A level is accepted once every one of the last DB enabled cycles disagreed with value.
      for (int i = 0; i < W; i++) begin
        if (hist.size() == DB) begin
          acc[i] = 1'b1;
          foreach (hist[k]) if (!hist[k].en || hist[k].s[i] == m.value[i]) acc[i] = 1'b0;
        end
      end
      m.rise  = acc & ~m.value;
      m.fall  = acc & m.value;
      m.value = m.value ^ acc;
      m.pend  = new_pend;
      m.irq   = |new_pend;
      void'(m_pipe.pop_front());
      m_pipe.push_back(pad);
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected after the next edge.
  task automatic step(input logic rst_n, input logic [W-1:0] pad,
                      input logic en, input logic [W-1:0] clr);
    @(negedge clk);
    reset_n  = rst_n;
    pad_i    = pad;
    enable_i = en;
    clear_i  = clr;
    model_edge(rst_n, pad, en, clr);
    expq.push_back(m);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        x = expq.pop_front();
        chk("sb_value",   32'(value_o),   32'(x.value));
        chk("sb_rise",    32'(rise_o),    32'(x.rise));
        chk("sb_fall",    32'(fall_o),    32'(x.fall));
        chk("sb_pending", 32'(pending_o), 32'(x.pend));
        chk("sb_irq",     32'(irq_o),     32'(x.irq));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int           lat;
    logic [W-1:0] pad;
    logic         en;
    logic         rn;
    reset_n  = 1'b0;
    pad_i    = 4'hF;
    enable_i = 1'b1;
    clear_i  = '0;
    model_reset();

    // Reset held two cycles with pads high.
    step(0, 4'hF, 1, 4'h0); after_edge();
    chk("rst_rise", 32'(rise_o), 32'h0);
    step(0, 4'hF, 1, 4'h0); after_edge();
    chk("rst_value", 32'(value_o), 32'h0);
    chk("rst_pending", 32'(pending_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    step(1, 4'h0, 1, 4'h0);
    repeat (8) step(1, 4'h0, 1, 4'h0);

    // Clean rising edge on bit 0: accepted exactly SYNC+DB edges after first sampling edge.
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1, 4'h1, 1, 4'h0); after_edge();
      if (value_o[0] === 1'b1) begin lat = n; break; end
    end
    chk("edge_latency", 32'(lat), 32'(SYNC + DB));
    chk("edge_rise", 32'(rise_o), 32'h1);
    step(1, 4'h1, 1, 4'h0); after_edge();
    chk("edge_rise_one_cycle", 32'(rise_o), 32'h0);
    chk("edge_pending", 32'(pending_o), 32'h1);
    chk("edge_irq", 32'(irq_o), 32'h1);

    // Glitch of 3 cycles on bit 1 is discarded; 4-cycle pulse is accepted.
    repeat (3) step(1, 4'h3, 1, 4'h0);
    repeat (10) step(1, 4'h1, 1, 4'h0);
    after_edge();
    chk("glitch_value", 32'(value_o), 32'h1);
    chk("glitch_pending", 32'(pending_o), 32'h1);
    repeat (4) step(1, 4'h3, 1, 4'h0);
    repeat (12) step(1, 4'h1, 1, 4'h0);
    after_edge();
    chk("pulse_pending", 32'(pending_o), 32'h3);

    // Clear everything, then race a clear against the falling pulse on bit 0.
    step(1, 4'h1, 1, 4'hF);
    repeat (2) step(1, 4'h1, 1, 4'h0);
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      if (m.fall[0]) begin lat = 1; break; end
      step(1, 4'h0, 1, 4'h0);
    end
    chk("race_fall_seen", 32'(lat), 32'h1);
    step(1, 4'h0, 1, 4'h1); after_edge();
    chk("race_set_wins", 32'(pending_o), 32'h1);
    step(1, 4'h0, 1, 4'h1); after_edge();
    chk("race_cleared", 32'(pending_o), 32'h0);
    chk("race_irq", 32'(irq_o), 32'h0);

    // Disabled: outputs frozen while pads toggle; re-enable accepts after DB edges.
    for (int n = 0; n < 20; n++) step(1, (n % 2 == 0) ? 4'hA : 4'h5, 0, 4'h0);
    repeat (3) step(1, 4'hA, 0, 4'h0);
    after_edge();
    chk("dis_value", 32'(value_o), 32'h0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1, 4'hA, 1, 4'h0); after_edge();
      if (value_o === 4'hA) begin lat = n; break; end
    end
    chk("en_latency", 32'(lat), 32'(DB));
    chk("en_rise", 32'(rise_o), 32'hA);

    // Reset in the middle of a debounce window on bit 2.
    step(1, 4'h0, 1, 4'hF);
    repeat (12) step(1, 4'h0, 1, 4'hF);
    repeat (4) step(1, 4'h4, 1, 4'h0);
    step(0, 4'h4, 1, 4'h0); after_edge();
    chk("mid_rst_value", 32'(value_o), 32'h0);
    chk("mid_rst_rise", 32'(rise_o), 32'h0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1, 4'h4, 1, 4'h0); after_edge();
      if (value_o[2] === 1'b1) begin lat = n; break; end
    end
    chk("mid_rst_latency", 32'(lat), 32'(SYNC + DB));

    // Random traffic: slow-changing pads mixing glitches and accepted edges.
    pad = 4'h4;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(0, 6) == 0) pad[i] = ~pad[i];
      en = ($urandom_range(0, 24) != 0);
      rn = ($urandom_range(0, 299) != 0);
      step(rn, pad, en, W'($urandom & $urandom & $urandom));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(expq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
